// File: rtl/tetris_pkg.sv
// ============================================================================
// Module  : tetris_pkg
// Brief   : Shared move command encoding, keycodes, auto-repeat states and
//           per-level gravity thresholds for the move scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tetris_pkg;

  // Command stream encoding seen by the Game engine
  typedef enum logic [2:0] {
    NONE    = 3'd0,
    LEFT    = 3'd1,
    RIGHT   = 3'd2,
    DOWN    = 3'd3,
    ROT_R   = 3'd4,
    ROT_L   = 3'd5,
    GRAVITY = 3'd6
  } move_t;

  // Auto-repeat key tracker states
  typedef enum logic [1:0] {
    AR_IDLE    = 2'd0,
    AR_HOLD    = 2'd1,
    AR_REPEAT  = 2'd2,
    AR_BLOCKED = 2'd3
  } ar_state_t;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_LEFT  = 8'h80;
  localparam logic [7:0] KEY_RIGHT = 8'h79;
  localparam logic [7:0] KEY_DOWN  = 8'h81;
  localparam logic [7:0] KEY_ROT_R = 8'h82;
  localparam logic [7:0] KEY_ROT_L = 8'h29;

  localparam int LEVEL_MAX = 6;

  // Cycles between gravity ticks per level (real clock and simulation scale)
  localparam logic [31:0] GRAV_THR [0:6] = '{
    32'd100_000_000, 32'd75_000_000, 32'd50_000_000, 32'd25_000_000,
    32'd20_000_000,  32'd15_000_000, 32'd10_000_000
  };
  localparam logic [31:0] GRAV_FAST [0:6] = '{
    32'd100, 32'd75, 32'd50, 32'd25, 32'd20, 32'd15, 32'd10
  };

  // Unknown keycodes behave exactly like "no key"
  function automatic move_t key_decode(input logic [7:0] code);
    case (code)
      KEY_LEFT:  return LEFT;
      KEY_RIGHT: return RIGHT;
      KEY_DOWN:  return DOWN;
      KEY_ROT_R: return ROT_R;
      KEY_ROT_L: return ROT_L;
      default:   return NONE;
    endcase
  endfunction

  // Only translation keys auto-repeat; rotations fire once per press
  function automatic logic is_move_key(input move_t m);
    return (m == LEFT) || (m == RIGHT) || (m == DOWN);
  endfunction

endpackage

`default_nettype wire

// File: rtl/move_scheduler_autorepeat_fsm.sv
// ============================================================================
// Module  : autorepeat_fsm
// Brief   : Decodes keycodes and produces one pend pulse per press plus
//           DAS/ARR auto-repeat pulses while a move key stays held.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module autorepeat_fsm
  import tetris_pkg::*;
#(
  parameter int DAS_DELAY  = 16_000_000,
  parameter int ARR_PERIOD = 5_000_000,
  parameter int CNT_W      = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_enable,
  input  logic [7:0] i_key,
  input  logic       i_lock_flush,
  output logic       o_pend,
  output logic [2:0] o_code
);

  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_DELAY - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_PERIOD - 1);

  ar_state_t        r_state, w_state_nxt;
  move_t            r_latched, w_latched_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_last;
  move_t            w_key, w_code;
  logic             w_pend;

  assign w_key  = key_decode(i_key);
  assign o_pend = w_pend;
  assign o_code = w_code;

  // State, latched key and DAS/ARR counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= AR_IDLE;
      r_latched <= NONE;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_latched <= w_latched_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // Next-state and pend pulse; a piece lock overrides everything and a held key is blocked
  always_comb begin
    w_state_nxt   = r_state;
    w_latched_nxt = r_latched;
    w_cnt_nxt     = r_cnt;
    w_pend        = 1'b0;
    w_code        = NONE;
    w_last        = (r_state == AR_HOLD) ? DAS_LAST : ARR_LAST;
    if (i_lock_flush) begin
      w_state_nxt   = (w_key != NONE) ? AR_BLOCKED : AR_IDLE;
      w_latched_nxt = NONE;
      w_cnt_nxt     = '0;
    end else if (i_enable) begin
      case (r_state)
        AR_IDLE: begin
          if (w_key != NONE) begin
            w_pend        = 1'b1;
            w_code        = w_key;
            w_latched_nxt = w_key;
            w_cnt_nxt     = '0;
            w_state_nxt   = AR_HOLD;
          end
        end
        AR_HOLD, AR_REPEAT: begin
          if (w_key == NONE) begin
            w_state_nxt = AR_IDLE;
            w_cnt_nxt   = '0;
          end else if (w_key != r_latched) begin
            // A different key counts as a fresh press in this same cycle
            w_pend        = 1'b1;
            w_code        = w_key;
            w_latched_nxt = w_key;
            w_cnt_nxt     = '0;
            w_state_nxt   = AR_HOLD;
          end else if (is_move_key(w_key)) begin
            if (r_cnt == w_last) begin
              w_pend      = 1'b1;
              w_code      = w_key;
              w_cnt_nxt   = '0;
              w_state_nxt = AR_REPEAT;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        AR_BLOCKED: begin
          if (w_key == NONE) w_state_nxt = AR_IDLE;
        end
        default: w_state_nxt = AR_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/move_scheduler.sv
// ============================================================================
// Module  : move_scheduler
// Brief   : Merges level-scaled gravity ticks and auto-repeated key moves into
//           a single registered valid/ready command stream for the Game engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module move_scheduler
  import tetris_pkg::*;
#(
  parameter int DAS_DELAY  = 16_000_000,
  parameter int ARR_PERIOD = 5_000_000,
  parameter int SIM_FAST   = 0,
  parameter int CNT_W      = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_enable,
  input  logic [7:0] i_key,
  input  logic [2:0] i_level,
  input  logic       i_lock_flush,
  output logic       o_cmd_valid,
  output logic [2:0] o_cmd,
  input  logic       i_cmd_ready
);

  logic [CNT_W-1:0] r_grav_cnt, w_thr;
  logic [2:0]       w_lvl;
  logic             w_grav_fire, w_hs, w_down_acc;
  logic             w_ar_pend;
  logic [2:0]       w_ar_code;
  logic             r_gpend, r_kpend, r_valid;
  move_t            r_kcode, r_cmd;
  logic             w_load, w_take_g, w_take_k, w_drop_down, w_kpend_left;

  autorepeat_fsm #(
    .DAS_DELAY  (DAS_DELAY),
    .ARR_PERIOD (ARR_PERIOD),
    .CNT_W      (CNT_W)
  ) u_autorepeat (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (i_enable),
    .i_key        (i_key),
    .i_lock_flush (i_lock_flush),
    .o_pend       (w_ar_pend),
    .o_code       (w_ar_code)
  );

  assign w_lvl       = (i_level > 3'(LEVEL_MAX)) ? 3'(LEVEL_MAX) : i_level;
  assign w_thr       = (SIM_FAST != 0) ? CNT_W'(GRAV_FAST[w_lvl]) : CNT_W'(GRAV_THR[w_lvl]);
  assign w_grav_fire = i_enable & (r_grav_cnt == w_thr - CNT_W'(1));
  assign w_hs        = r_valid & i_cmd_ready;
  assign w_down_acc  = w_hs & (r_cmd == DOWN);

  // Gravity period counter; a lock or an accepted soft-drop restarts the period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grav_cnt <= '0;
    end else if (i_lock_flush || w_down_acc) begin
      r_grav_cnt <= '0;
    end else if (i_enable) begin
      r_grav_cnt <= w_grav_fire ? '0 : r_grav_cnt + CNT_W'(1);
    end
  end

  // Arbitration: the slot refills when empty or being accepted; gravity wins and absorbs a pending DOWN
  always_comb begin
    w_load       = ~r_valid | w_hs;
    w_take_g     = w_load & r_gpend;
    w_take_k     = w_load & ~r_gpend & r_kpend;
    w_drop_down  = w_take_g & r_kpend & (r_kcode == DOWN);
    w_kpend_left = r_kpend & ~w_take_k & ~w_drop_down;
  end

  // One-deep pending flags; repeats of an event still pending are coalesced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gpend <= 1'b0;
      r_kpend <= 1'b0;
      r_kcode <= NONE;
    end else if (i_lock_flush) begin
      r_gpend <= 1'b0;
      r_kpend <= 1'b0;
      r_kcode <= NONE;
    end else begin
      r_gpend <= (r_gpend & ~w_take_g) | w_grav_fire;
      if (w_ar_pend && !w_kpend_left) begin
        r_kpend <= 1'b1;
        r_kcode <= move_t'(w_ar_code);
      end else begin
        r_kpend <= w_kpend_left;
      end
    end
  end

  // Registered output slot, held stable until accepted or flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_cmd   <= NONE;
    end else if (i_lock_flush) begin
      r_valid <= 1'b0;
      r_cmd   <= NONE;
    end else if (w_load) begin
      r_valid <= w_take_g | w_take_k;
      r_cmd   <= w_take_g ? GRAVITY : (w_take_k ? r_kcode : NONE);
    end
  end

  assign o_cmd_valid = r_valid;
  assign o_cmd       = r_cmd;

endmodule

`default_nettype wire

// File: tb/tb_move_scheduler.sv
// ============================================================================
// Module  : tb_move_scheduler
// Brief   : Randomized scoreboard bench for move_scheduler against an
//           event-level reference model of gravity and key auto-repeat.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_move_scheduler;
  import tetris_pkg::*;

  localparam int DAS = 20;
  localparam int ARR = 5;

  logic       clk;
  logic       rst_n;
  logic       i_enable;
  logic [7:0] i_key;
  logic [2:0] i_level;
  logic       i_lock_flush;
  logic       o_cmd_valid;
  logic [2:0] o_cmd;
  logic       i_cmd_ready;

  move_scheduler #(
    .DAS_DELAY  (DAS),
    .ARR_PERIOD (ARR),
    .SIM_FAST   (1),
    .CNT_W      (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (i_enable),
    .i_key        (i_key),
    .i_level      (i_level),
    .i_lock_flush (i_lock_flush),
    .o_cmd_valid  (o_cmd_valid),
    .o_cmd        (o_cmd),
    .i_cmd_ready  (i_cmd_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  code;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned cyc      = 0;

  // Reference model state: what the Game should see, expressed as events
  bit              m_valid;
  move_t           m_cmd;
  bit              m_gpend;
  bit              m_kpend;
  move_t           m_kcode;
  longint unsigned m_gcnt;     // enabled cycles since gravity last restarted
  move_t           m_held;     // key currently held and tracked
  int unsigned     m_age;      // enabled cycles the tracked key has been held
  bit              m_blocked;  // key held across a piece lock

  int         grav_tbl [7] = '{100, 75, 50, 25, 20, 15, 10};
  logic [7:0] keys     [7] = '{8'h00, 8'h80, 8'h79, 8'h81, 8'h82, 8'h29, 8'h55};

  function automatic move_t tb_decode(input logic [7:0] kc);
    case (kc)
      8'h80:   return LEFT;
      8'h79:   return RIGHT;
      8'h81:   return DOWN;
      8'h82:   return ROT_R;
      8'h29:   return ROT_L;
      default: return NONE;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_cmd = NONE; m_gpend = 0; m_kpend = 0; m_kcode = NONE;
    m_gcnt = 0; m_held = NONE; m_age = 0; m_blocked = 0;
  endtask

  // Advance the model across one clock edge using the inputs presented before it
  task automatic model_edge();
    bit    hs, down_acc, fire, kev;
    move_t k, kev_code;
    int    lv;
    hs       = m_valid && i_cmd_ready;
    down_acc = hs && (m_cmd == DOWN);
    k        = tb_decode(i_key);
    fire     = 0;
    kev      = 0;
    kev_code = NONE;
    if (i_lock_flush) begin
      model_reset();
      m_blocked = (k != NONE);
    end else begin
      if (i_enable) begin
        lv = (int'(i_level) > 6) ? 6 : int'(i_level);
        if (m_gcnt + 1 == longint'(grav_tbl[lv])) begin
          fire = 1; m_gcnt = 0;
        end else begin
          m_gcnt++;
        end
        if (m_blocked) begin
          if (k == NONE) m_blocked = 0;
        end else if (k == NONE) begin
          m_held = NONE;
        end else if (k != m_held) begin
          kev = 1; kev_code = k; m_held = k; m_age = 0;
        end else begin
          m_age++;
          if ((k == LEFT || k == RIGHT || k == DOWN) && m_age >= DAS && (m_age - DAS) % ARR == 0) begin
            kev = 1; kev_code = k;
          end
        end
      end
      if (down_acc) m_gcnt = 0;
      if (!m_valid || hs) begin
        if (m_gpend) begin
          m_valid = 1; m_cmd = GRAVITY; m_gpend = 0;
          if (m_kpend && m_kcode == DOWN) m_kpend = 0;
        end else if (m_kpend) begin
          m_valid = 1; m_cmd = m_kcode; m_kpend = 0;
        end else begin
          m_valid = 0; m_cmd = NONE;
        end
      end
      if (fire) m_gpend = 1;
      if (kev && !m_kpend) begin
        m_kpend = 1; m_kcode = kev_code;
      end
    end
  endtask

  // Inputs are already set: record any expected handshake, then cross the edge
  task automatic step();
    exp_t e;
    if (m_valid && i_cmd_ready) begin
      e.cyc  = cyc;
      e.code = m_cmd;
      q.push_back(e);
    end
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Monitor: every DUT handshake must match the next expected command and cycle
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_cmd_valid && i_cmd_ready) begin
          n_checks++;
          if (q.size() == 0) begin
            $display("FAIL handshake: got cmd=%0d at cycle %0d, expected no command", o_cmd, cyc);
          end else begin
            e = q.pop_front();
            if (e.code == o_cmd && e.cyc == cyc) n_pass++;
            else $display("FAIL handshake: got cmd=%0d at cycle %0d, expected cmd=%0d at cycle %0d",
                          o_cmd, cyc, e.code, e.cyc);
          end
        end
        while (q.size() != 0 && q[0].cyc < cyc) begin
          n_checks++;
          e = q.pop_front();
          $display("FAIL missed handshake: got none, expected cmd=%0d at cycle %0d", e.code, e.cyc);
        end
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0; i_enable = 1'b1; i_key = 8'h00; i_level = 3'd0;
    i_lock_flush = 1'b0; i_cmd_ready = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("reset_valid", int'(o_cmd_valid), 0);
    check("reset_cmd", int'(o_cmd), int'(NONE));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;

    // Gravity alone at level 0
    run(350);

    // LEFT held 40 cycles: press, DAS, then ARR repeats
    i_key = 8'h80; run(40);
    i_key = 8'h00; run(30);

    // Rotation never repeats; switching rotation key is a new press
    i_key = 8'h82; run(100);
    i_key = 8'h29; run(20);
    i_key = 8'h00; run(10);

    // Long stall with RIGHT held, then release
    i_cmd_ready = 1'b0; i_key = 8'h79; run(300);
    check("stall_valid", int'(o_cmd_valid), int'(m_valid));
    i_key = 8'h00; i_cmd_ready = 1'b1; run(20);

    // GRAVITY and DOWN pending together, then DOWN acceptance restarts gravity
    i_cmd_ready = 1'b0; i_key = 8'h81; run(120);
    i_cmd_ready = 1'b1; run(60);
    i_key = 8'h00; run(150);

    // Piece lock while DOWN held: blocked until release and new press
    i_key = 8'h81; run(30);
    i_lock_flush = 1'b1; step(); i_lock_flush = 1'b0;
    check("flush_valid", int'(o_cmd_valid), 0);
    run(40);
    i_key = 8'h00; run(3);
    i_key = 8'h81; run(10);
    i_key = 8'h00; run(20);

    // Higher levels
    i_level = 3'd5; run(80);
    i_level = 3'd7; run(60);
    i_level = 3'd0;
    i_lock_flush = 1'b1; step(); i_lock_flush = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19, 0) == 0) i_key = keys[$urandom_range(6, 0)];
      i_cmd_ready  = ($urandom_range(3, 0) != 0);
      i_lock_flush = ($urandom_range(199, 0) == 0);
      if ($urandom_range(49, 0) == 0) i_enable = ~i_enable;
      if ($urandom_range(299, 0) == 0) i_level = 3'($urandom_range(7, 0));
      step();
    end
    i_enable = 1'b1; i_lock_flush = 1'b1; i_level = 3'd0; i_key = 8'h00; i_cmd_ready = 1'b1;
    step(); i_lock_flush = 1'b0;
    run(5);

    // Asynchronous reset in the middle of auto-repeat
    i_key = 8'h80; run(35);
    i_cmd_ready = 1'b0; run(8);
    check("pre_reset_valid", int'(o_cmd_valid), int'(m_valid));
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    check("async_reset_valid", int'(o_cmd_valid), 0);
    check("async_reset_cmd", int'(o_cmd), int'(NONE));
    i_key = 8'h00; i_cmd_ready = 1'b1;
    model_reset();
    repeat (3) begin @(posedge clk); cyc++; end
    #1 rst_n = 1'b1;
    i_key = 8'h80; run(40);
    i_key = 8'h00; run(20);

    @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
